// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline: ALU op/result-class enums,
// opcode map and instruction field slices for the 16-bit R/I-type format.
package cpu_pkg;

    localparam int CPU_DATA_W  = 16;
    localparam int CPU_INST_W  = 16;
    localparam int CPU_RADDR_W = 4;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_OR  = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3,
        ALU_ADD = 4'd4,
        ALU_SUB = 4'd5,
        ALU_LW  = 4'd6,
        ALU_SW  = 4'd7
    } aluop_t;

    typedef enum logic [1:0] {
        SEL_NOP   = 2'd0,
        SEL_LOGIC = 2'd1,
        SEL_ARITH = 2'd2,
        SEL_MEM   = 2'd3
    } alusel_t;

    // R-type opcodes occupy 0x01-0x05, I-type 0x08-0x0B, memory 0x10-0x11.
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_OR   = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_XOR  = 6'h03;
    localparam logic [5:0] OP_ADD  = 6'h04;
    localparam logic [5:0] OP_SUB  = 6'h05;
    localparam logic [5:0] OP_ORI  = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_XORI = 6'h0A;
    localparam logic [5:0] OP_ADDI = 6'h0B;
    localparam logic [5:0] OP_LW   = 6'h10;
    localparam logic [5:0] OP_SW   = 6'h11;

    function automatic logic [5:0] inst_op(input logic [15:0] inst);
        return inst[15:10];
    endfunction

    function automatic logic [3:0] inst_rd(input logic [15:0] inst);
        return inst[9:6];
    endfunction

    function automatic logic [3:0] inst_rs(input logic [15:0] inst);
        return inst[5:2];
    endfunction

    function automatic logic [5:0] inst_imm(input logic [15:0] inst);
        return inst[5:0];
    endfunction

endpackage

// File: rtl/id_decode_core.sv
// Combinational opcode decoder: produces ALU controls, register-file read
// enables/addresses, destination, and the extended immediate for I-type ops.
module id_decode_core
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int INST_W  = CPU_INST_W,
    parameter int RADDR_W = CPU_RADDR_W
) (
    input  logic [INST_W-1:0]  inst,
    output aluop_t             aluop,
    output alusel_t            alusel,
    output logic               reg1_read,
    output logic [RADDR_W-1:0] reg1_addr,
    output logic               reg2_read,
    output logic [RADDR_W-1:0] reg2_addr,
    output logic [RADDR_W-1:0] wd,
    output logic               wreg,
    output logic               use_imm,
    output logic [DATA_W-1:0]  imm,
    output logic               is_load,
    output logic               is_store,
    output logic               illegal
);

    logic [5:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs;
    logic [5:0]         imm6;
    logic [DATA_W-1:0]  imm_zext;
    logic [DATA_W-1:0]  imm_sext;

    assign op       = inst_op(inst[15:0]);
    assign rd       = RADDR_W'(inst_rd(inst[15:0]));
    assign rs       = RADDR_W'(inst_rs(inst[15:0]));
    assign imm6     = inst_imm(inst[15:0]);
    assign imm_zext = {{(DATA_W-6){1'b0}}, imm6};
    assign imm_sext = {{(DATA_W-6){imm6[5]}}, imm6};
    assign wd       = rd;

    // Port 1 normally reads rd (accumulator style); memory ops swap so the
    // address register rs goes out on port 1 and store data on port 2.
    always_comb begin
        aluop     = ALU_NOP;
        alusel    = SEL_NOP;
        reg1_read = 1'b0;
        reg2_read = 1'b0;
        reg1_addr = rd;
        reg2_addr = rs;
        wreg      = 1'b0;
        use_imm   = 1'b0;
        imm       = '0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_NOP: ;
            OP_OR, OP_AND, OP_XOR, OP_ADD, OP_SUB: begin
                reg1_read = 1'b1;
                reg2_read = 1'b1;
                wreg      = 1'b1;
                case (op)
                    OP_OR:   begin aluop = ALU_OR;  alusel = SEL_LOGIC; end
                    OP_AND:  begin aluop = ALU_AND; alusel = SEL_LOGIC; end
                    OP_XOR:  begin aluop = ALU_XOR; alusel = SEL_LOGIC; end
                    OP_ADD:  begin aluop = ALU_ADD; alusel = SEL_ARITH; end
                    default: begin aluop = ALU_SUB; alusel = SEL_ARITH; end
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                reg1_read = 1'b1;
                wreg      = 1'b1;
                use_imm   = 1'b1;
                imm       = imm_zext;
                alusel    = SEL_LOGIC;
                case (op)
                    OP_ORI:  aluop = ALU_OR;
                    OP_ANDI: aluop = ALU_AND;
                    default: aluop = ALU_XOR;
                endcase
            end
            OP_ADDI: begin
                reg1_read = 1'b1;
                wreg      = 1'b1;
                use_imm   = 1'b1;
                imm       = imm_sext;
                aluop     = ALU_ADD;
                alusel    = SEL_ARITH;
            end
            OP_LW: begin
                reg1_read = 1'b1;
                reg1_addr = rs;
                wreg      = 1'b1;
                is_load   = 1'b1;
                aluop     = ALU_LW;
                alusel    = SEL_MEM;
            end
            OP_SW: begin
                reg1_read = 1'b1;
                reg1_addr = rs;
                reg2_read = 1'b1;
                reg2_addr = rd;
                is_store  = 1'b1;
                aluop     = ALU_SW;
                alusel    = SEL_MEM;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage: hazard detection, EX/MEM forwarding,
// valid/ready handshake and the ID/EX register. Define ID_FWD_EN for forwarding.
module id_stage_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int INST_W  = CPU_INST_W,
    parameter int RADDR_W = CPU_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid_i,
    output logic               if_ready_o,
    input  logic [15:0]        if_pc_i,
    input  logic [INST_W-1:0]  if_inst_i,
    output logic               reg1_read_o,
    output logic [RADDR_W-1:0] reg1_addr_o,
    input  logic [DATA_W-1:0]  reg1_data_i,
    output logic               reg2_read_o,
    output logic [RADDR_W-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0]  reg2_data_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic               ex_is_load_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic               flush_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [15:0]        pc_o,
    output aluop_t             aluop_o,
    output alusel_t            alusel_o,
    output logic [DATA_W-1:0]  reg1_o,
    output logic [DATA_W-1:0]  reg2_o,
    output logic [RADDR_W-1:0] wd_o,
    output logic               wreg_o,
    output logic               is_load_o,
    output logic               is_store_o,
    output logic               illegal_o
);

    aluop_t             dec_aluop;
    alusel_t            dec_alusel;
    logic [RADDR_W-1:0] dec_wd;
    logic               dec_wreg;
    logic               dec_use_imm;
    logic [DATA_W-1:0]  dec_imm;
    logic               dec_is_load;
    logic               dec_is_store;
    logic               dec_illegal;

    logic               ex_hit1;
    logic               ex_hit2;
    logic               mem_hit1;
    logic               mem_hit2;
    logic               stall;
    logic               accept;
    logic [DATA_W-1:0]  src1;
    logic [DATA_W-1:0]  src2;
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;

    id_decode_core #(
        .DATA_W  (DATA_W),
        .INST_W  (INST_W),
        .RADDR_W (RADDR_W)
    ) u_decode (
        .inst      (if_inst_i),
        .aluop     (dec_aluop),
        .alusel    (dec_alusel),
        .reg1_read (reg1_read_o),
        .reg1_addr (reg1_addr_o),
        .reg2_read (reg2_read_o),
        .reg2_addr (reg2_addr_o),
        .wd        (dec_wd),
        .wreg      (dec_wreg),
        .use_imm   (dec_use_imm),
        .imm       (dec_imm),
        .is_load   (dec_is_load),
        .is_store  (dec_is_store),
        .illegal   (dec_illegal)
    );

    assign ex_hit1  = reg1_read_o & ex_wreg_i  & (ex_wd_i  == reg1_addr_o);
    assign ex_hit2  = reg2_read_o & ex_wreg_i  & (ex_wd_i  == reg2_addr_o);
    assign mem_hit1 = reg1_read_o & mem_wreg_i & (mem_wd_i == reg1_addr_o);
    assign mem_hit2 = reg2_read_o & mem_wreg_i & (mem_wd_i == reg2_addr_o);

`ifdef ID_FWD_EN
    // Only a load in EX is unresolvable: its data arrives one stage later.
    assign stall = (ex_hit1 | ex_hit2) & ex_is_load_i;

    always_comb begin
        src1 = reg1_data_i;
        src2 = reg2_data_i;
        if (ex_hit1)       src1 = ex_wdata_i;
        else if (mem_hit1) src1 = mem_wdata_i;
        if (ex_hit2)       src2 = ex_wdata_i;
        else if (mem_hit2) src2 = mem_wdata_i;
    end
`else
    // Without bypass paths, wait until every in-flight writer has retired.
    logic unused_fwd;
    assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
    assign stall = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
    assign src1  = reg1_data_i;
    assign src2  = reg2_data_i;
`endif

    assign op1 = reg1_read_o ? src1 : '0;
    assign op2 = reg2_read_o ? src2 : (dec_use_imm ? dec_imm : '0);

    assign if_ready_o = ~stall & (~ex_valid_o | ex_ready_i);
    assign accept     = if_valid_i & if_ready_o;

    // Flush outranks a new transfer; a consumed slot with nothing behind it
    // becomes a bubble while its payload fields are simply left in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_o <= 1'b0;
            pc_o       <= '0;
            aluop_o    <= ALU_NOP;
            alusel_o   <= SEL_NOP;
            reg1_o     <= '0;
            reg2_o     <= '0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            is_load_o  <= 1'b0;
            is_store_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (accept) begin
            ex_valid_o <= 1'b1;
            pc_o       <= if_pc_i;
            aluop_o    <= dec_aluop;
            alusel_o   <= dec_alusel;
            reg1_o     <= op1;
            reg2_o     <= op2;
            wd_o       <= dec_wd;
            wreg_o     <= dec_wreg;
            is_load_o  <= dec_is_load;
            is_store_o <= dec_is_store;
            illegal_o  <= dec_illegal;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; expectations follow ID_FWD_EN.
module tb_id_stage_pipe;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i, if_ready_o;
    logic [15:0] if_pc_i, if_inst_i;
    logic        reg1_read_o, reg2_read_o;
    logic [3:0]  reg1_addr_o, reg2_addr_o;
    logic [15:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [3:0]  ex_wd_i, mem_wd_i;
    logic [15:0] ex_wdata_i, mem_wdata_i;
    logic        flush_i, ex_valid_o, ex_ready_i;
    logic [15:0] pc_o, reg1_o, reg2_o;
    aluop_t      aluop_o;
    alusel_t     alusel_o;
    logic [3:0]  wd_o;
    logic        wreg_o, is_load_o, is_store_o, illegal_o;

    logic [15:0] regs [16];
    int vectors = 0;
    int miscompares = 0;

    assign reg1_data_i = regs[reg1_addr_o];
    assign reg2_data_i = regs[reg2_addr_o];

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
        .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
        .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .is_load_o(is_load_o), .is_store_o(is_store_o),
        .illegal_o(illegal_o)
    );

    task automatic idle();
        if_valid_i = 0; if_pc_i = 0; if_inst_i = 0;
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
        flush_i = 0; ex_ready_i = 1;
    endtask

    task automatic present(input logic [15:0] pc, input logic [15:0] inst);
        if_valid_i = 1; if_pc_i = pc; if_inst_i = inst;
    endtask

    task automatic test_reset();
        rst = 0; idle();
        @(posedge clk); @(posedge clk); #1;
        vectors++; if (ex_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid_o); end
        vectors++; if (aluop_o !== ALU_NOP) begin miscompares++; $display("[TB] FAIL reset_aluop: got %0d expected %0d", aluop_o, ALU_NOP); end
        vectors++; if ({reg1_o, reg2_o, pc_o} !== 48'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0", {reg1_o, reg2_o, pc_o}); end
        vectors++; if ({wreg_o, illegal_o, is_load_o} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {wreg_o, illegal_o, is_load_o}); end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_ori();
        @(negedge clk); regs[3] = 16'h0101; present(16'h0040, 16'h20EA); #1;
        vectors++; if (reg1_addr_o !== 4'd3) begin miscompares++; $display("[TB] FAIL ori_addr1: got %0d expected 3", reg1_addr_o); end
        vectors++; if ({reg1_read_o, reg2_read_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL ori_reads: got %b expected 10", {reg1_read_o, reg2_read_o}); end
        @(posedge clk); #1;
        vectors++; if (reg1_o !== 16'h0101) begin miscompares++; $display("[TB] FAIL ori_reg1: got %h expected 0101", reg1_o); end
        vectors++; if (reg2_o !== 16'h002A) begin miscompares++; $display("[TB] FAIL ori_reg2: got %h expected 002a", reg2_o); end
        vectors++; if (aluop_o !== ALU_OR) begin miscompares++; $display("[TB] FAIL ori_aluop: got %0d expected %0d", aluop_o, ALU_OR); end
        vectors++; if ({wd_o, wreg_o, ex_valid_o} !== 6'b0011_1_1) begin miscompares++; $display("[TB] FAIL ori_wd: got %b expected 001111", {wd_o, wreg_o, ex_valid_o}); end
        vectors++; if (pc_o !== 16'h0040) begin miscompares++; $display("[TB] FAIL ori_pc: got %h expected 0040", pc_o); end
        @(negedge clk); if_valid_i = 0;
        @(posedge clk); #1;
        vectors++; if (ex_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_valid: got %b expected 0", ex_valid_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); regs[1] = 16'hFFFF; regs[2] = 16'h0001; present(16'h0044, 16'h2C7F);
        @(posedge clk); #1;
        vectors++; if (reg2_o !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL addi_imm: got %h expected ffff", reg2_o); end
        vectors++; if (alusel_o !== SEL_ARITH) begin miscompares++; $display("[TB] FAIL addi_sel: got %0d expected %0d", alusel_o, SEL_ARITH); end
        @(negedge clk); present(16'h0046, 16'h1048);
        @(posedge clk); #1;
        vectors++; if ({reg1_o, reg2_o} !== 32'hFFFF_0001) begin miscompares++; $display("[TB] FAIL add_ops: got %h expected ffff0001", {reg1_o, reg2_o}); end
        vectors++; if ({aluop_o, wd_o, ex_valid_o} !== {ALU_ADD, 4'd1, 1'b1}) begin miscompares++; $display("[TB] FAIL add_ctrl: got %h expected %h", {aluop_o, wd_o, ex_valid_o}, {ALU_ADD, 4'd1, 1'b1}); end
        vectors++; if (pc_o !== 16'h0046) begin miscompares++; $display("[TB] FAIL add_pc: got %h expected 0046", pc_o); end
        @(negedge clk); idle();
    endtask

    task automatic test_load_store();
        @(negedge clk); regs[2] = 16'h2222; regs[3] = 16'h3333; present(16'h0050, 16'h44C8); #1;
        vectors++; if ({reg1_addr_o, reg2_addr_o, reg2_read_o} !== {4'd2, 4'd3, 1'b1}) begin miscompares++; $display("[TB] FAIL sw_addrs: got %h expected %h", {reg1_addr_o, reg2_addr_o, reg2_read_o}, {4'd2, 4'd3, 1'b1}); end
        @(posedge clk); #1;
        vectors++; if ({reg1_o, reg2_o} !== 32'h2222_3333) begin miscompares++; $display("[TB] FAIL sw_ops: got %h expected 22223333", {reg1_o, reg2_o}); end
        vectors++; if ({wreg_o, is_store_o, is_load_o} !== 3'b010) begin miscompares++; $display("[TB] FAIL sw_ctrl: got %b expected 010", {wreg_o, is_store_o, is_load_o}); end
        @(negedge clk); idle();
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        regs[2] = 16'h2222; regs[5] = 16'h0F0F; present(16'h0060, 16'h0494);
        ex_wreg_i = 1; ex_wd_i = 5; ex_wdata_i = 16'h1234;
        mem_wreg_i = 1; mem_wd_i = 5; mem_wdata_i = 16'h5555; #1;
`ifdef ID_FWD_EN
        vectors++; if (if_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL fwd_ready: got %b expected 1", if_ready_o); end
        @(posedge clk); #1;
        vectors++; if ({reg1_o, reg2_o} !== 32'h2222_1234) begin miscompares++; $display("[TB] FAIL fwd_ex_wins: got %h expected 22221234", {reg1_o, reg2_o}); end
        @(negedge clk); ex_wreg_i = 0;
        @(posedge clk); #1;
        vectors++; if (reg2_o !== 16'h5555) begin miscompares++; $display("[TB] FAIL fwd_mem: got %h expected 5555", reg2_o); end
`else
        vectors++; if (if_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL nofwd_stall: got %b expected 0", if_ready_o); end
        @(posedge clk);
        @(negedge clk); ex_wreg_i = 0; mem_wreg_i = 0; #1;
        vectors++; if (if_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL nofwd_release: got %b expected 1", if_ready_o); end
        @(posedge clk); #1;
        vectors++; if ({reg1_o, reg2_o} !== 32'h2222_0F0F) begin miscompares++; $display("[TB] FAIL nofwd_regfile: got %h expected 22220f0f", {reg1_o, reg2_o}); end
`endif
        @(negedge clk); idle();
    endtask

    task automatic test_load_use();
        int stalls;
        int step;
        int expected_stalls;
`ifdef ID_FWD_EN
        expected_stalls = 1;
`else
        expected_stalls = 2;
`endif
        stalls = 0; step = 0;
        @(negedge clk); regs[9] = 16'h0900; regs[4] = 16'h0004; regs[6] = 16'h6666;
        present(16'h0080, 16'h4124);
        @(posedge clk); #1;
        vectors++; if ({is_load_o, wd_o, reg1_o} !== {1'b1, 4'd4, 16'h0900}) begin miscompares++; $display("[TB] FAIL lw_decode: got %h expected %h", {is_load_o, wd_o, reg1_o}, {1'b1, 4'd4, 16'h0900}); end
        @(negedge clk); present(16'h0082, 16'h1190);
        ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1; ex_wdata_i = 16'hDEAD;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (if_ready_o) break;
            stalls++;
            @(posedge clk); #1;
            if (c == 0) begin
                vectors++; if (ex_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_bubble: got %b expected 0", ex_valid_o); end
            end
            @(negedge clk);
            if (step == 0) begin
                ex_wreg_i = 0; ex_is_load_i = 0;
                mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 16'hBEEF; step = 1;
            end else if (step == 1) begin
                mem_wreg_i = 0; regs[4] = 16'hBEEF; step = 2;
            end
        end
        vectors++; if (stalls !== expected_stalls) begin miscompares++; $display("[TB] FAIL lu_stalls: got %0d expected %0d", stalls, expected_stalls); end
        @(posedge clk); #1;
        vectors++; if ({ex_valid_o, reg1_o, reg2_o} !== {1'b1, 16'h6666, 16'hBEEF}) begin miscompares++; $display("[TB] FAIL lu_ops: got %h expected %h", {ex_valid_o, reg1_o, reg2_o}, {1'b1, 16'h6666, 16'hBEEF}); end
        @(negedge clk); idle();
    endtask

    task automatic test_hold_flush();
        @(negedge clk); regs[7] = 16'h00FF; present(16'h0090, 16'h29D5);
        @(posedge clk); #1;
        vectors++; if ({reg1_o, reg2_o, aluop_o} !== {16'h00FF, 16'h0015, ALU_XOR}) begin miscompares++; $display("[TB] FAIL xori_ops: got %h expected %h", {reg1_o, reg2_o, aluop_o}, {16'h00FF, 16'h0015, ALU_XOR}); end
        @(negedge clk); ex_ready_i = 0; present(16'h0092, 16'h0494);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (if_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready: got %b expected 0", if_ready_o); end
            @(posedge clk); #1;
            vectors++; if ({ex_valid_o, reg1_o, pc_o} !== {1'b1, 16'h00FF, 16'h0090}) begin miscompares++; $display("[TB] FAIL hold_frozen: got %h expected %h", {ex_valid_o, reg1_o, pc_o}, {1'b1, 16'h00FF, 16'h0090}); end
            @(negedge clk);
        end
        flush_i = 1;
        @(posedge clk); #1;
        vectors++; if (ex_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_held: got %b expected 0", ex_valid_o); end
        @(negedge clk); ex_ready_i = 1; flush_i = 1; present(16'h0094, 16'h20EA);
        @(posedge clk); #1;
        vectors++; if (ex_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drop: got %b expected 0", ex_valid_o); end
        @(negedge clk); idle();
    endtask

    task automatic test_illegal_reset();
        @(negedge clk); present(16'h00A0, 16'hFC55);
        @(posedge clk); #1;
        vectors++; if ({ex_valid_o, illegal_o, wreg_o} !== 3'b110) begin miscompares++; $display("[TB] FAIL illegal_flags: got %b expected 110", {ex_valid_o, illegal_o, wreg_o}); end
        vectors++; if (aluop_o !== ALU_NOP) begin miscompares++; $display("[TB] FAIL illegal_aluop: got %0d expected %0d", aluop_o, ALU_NOP); end
        @(negedge clk); ex_ready_i = 0; if_valid_i = 0;
        @(posedge clk); #1;
        vectors++; if (illegal_o !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_held: got %b expected 1", illegal_o); end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        vectors++; if ({ex_valid_o, illegal_o, pc_o} !== 18'h0) begin miscompares++; $display("[TB] FAIL midhold_reset: got %h expected 0", {ex_valid_o, illegal_o, pc_o}); end
        @(negedge clk); rst = 1; idle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        test_reset();
        test_ori();
        test_back_to_back();
        test_load_store();
        test_fwd_priority();
        test_load_use();
        test_hold_flush();
        test_illegal_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
